// File: rtl/clk_rate_pkg.sv
// Shared definitions for the clock-rate controller: rate width, default/minimum divider
// max values, FSM state encodings and small rate helpers.
// Optional feature macro: CLK_RATE_RAMP_EN (enables the ramp helper).
package clk_rate_pkg;

  localparam int unsigned RATE_W = 32;
  typedef logic [RATE_W-1:0] rate_t;

  localparam rate_t DEFAULT_MAX_C = 32'd49_999_999;
  localparam rate_t MIN_MAX_C     = 32'd1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_RAMP      = 2'd2;
  localparam logic [1:0] ST_DWELL     = 2'd3;

  // Raise a request to the floor value.
  function automatic rate_t clamp_min(input rate_t v, input rate_t lo);
    return (v < lo) ? lo : v;
  endfunction

`ifdef CLK_RATE_RAMP_EN
  // One ramp step from cur toward tgt, never overshooting; both directions avoid underflow.
  function automatic rate_t ramp_next(input rate_t cur, input rate_t tgt, input rate_t step);
    rate_t diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff < step) ? tgt : cur + step;
    end else begin
      diff = cur - tgt;
      return (diff < step) ? tgt : cur - step;
    end
  endfunction
`endif

endpackage

// File: rtl/rise_detect.sv
// Single-clock rising-edge detector. The history register resets high so a signal that is
// already high when reset releases does not produce a pulse.
module rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic r_prev;

  // Track the previous sample of d.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= d;
    end
  end

  assign pulse = d & ~r_prev;

endmodule

// File: rtl/clk_rate_ctrl.sv
// Run-time rate controller for the flexible clock divider. Owns the divider max value and
// only changes it on a rising edge of the divided clock, holds each new rate for a number
// of divided edges, and forces the change if the divided clock stops.
// Optional feature macro: CLK_RATE_RAMP_EN (step toward the target by RAMP_STEP per edge).
module clk_rate_ctrl
  import clk_rate_pkg::*;
#(
  parameter rate_t       DEFAULT_MAX = DEFAULT_MAX_C,
  parameter rate_t       MIN_MAX     = MIN_MAX_C,
  parameter int unsigned DWELL_EDGES = 4,
  parameter rate_t       TIMEOUT_CYC = 32'd200_000_000
`ifdef CLK_RATE_RAMP_EN
  ,
  parameter rate_t       RAMP_STEP   = 32'd1_000_000
`endif
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [RATE_W-1:0] req_max,
  output logic              req_ready,
  input  logic              div_clk,
  output logic [RATE_W-1:0] max_out,
  output logic              busy,
  output logic              applied,
  output logic              clamped,
  output logic              timeout
);

  localparam int unsigned           DWELL_W    = $clog2(DWELL_EDGES + 1);
  localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL_EDGES - 1);
  localparam rate_t                 WAIT_LAST  = TIMEOUT_CYC - 32'd1;

  logic [1:0]         r_state;
  rate_t              r_target;
  rate_t              r_max;
  rate_t              r_wait_cnt;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_applied;
  logic               r_clamped;
  logic               r_timeout;

  logic  w_edge;
  rate_t w_req_target;

  rise_detect u_div_rise (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (div_clk),
    .pulse  (w_edge)
  );

  assign w_req_target = clamp_min(req_max, MIN_MAX);

`ifdef CLK_RATE_RAMP_EN
  rate_t w_ramp_max;
  assign w_ramp_max = ramp_next(r_max, r_target, RAMP_STEP);
`endif

  // Rate-change FSM: accept, wait for a divided edge (or ramp), then dwell.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_target    <= DEFAULT_MAX;
      r_max       <= DEFAULT_MAX;
      r_wait_cnt  <= '0;
      r_dwell_cnt <= '0;
      r_applied   <= 1'b0;
      r_clamped   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_applied <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_target   <= w_req_target;
            r_clamped  <= (req_max < MIN_MAX);
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
            if (w_req_target == r_max) begin
              r_applied <= 1'b1;
            end else begin
`ifdef CLK_RATE_RAMP_EN
              r_state <= ST_RAMP;
`else
              r_state <= ST_WAIT_EDGE;
`endif
            end
          end
        end
`ifdef CLK_RATE_RAMP_EN
        ST_RAMP: begin
          // An edge takes priority over an expiring wait counter.
          if (w_edge) begin
            r_max      <= w_ramp_max;
            r_wait_cnt <= '0;
            if (w_ramp_max == r_target) begin
              r_applied   <= 1'b1;
              r_dwell_cnt <= '0;
              r_state     <= ST_DWELL;
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_max       <= r_target;
            r_timeout   <= 1'b1;
            r_applied   <= 1'b1;
            r_dwell_cnt <= '0;
            r_state     <= ST_DWELL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        // Unreachable in this build; recover to idle.
        ST_WAIT_EDGE: r_state <= ST_IDLE;
`else
        ST_WAIT_EDGE: begin
          // An edge takes priority over an expiring wait counter.
          if (w_edge) begin
            r_max       <= r_target;
            r_applied   <= 1'b1;
            r_dwell_cnt <= '0;
            r_state     <= ST_DWELL;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_max       <= r_target;
            r_timeout   <= 1'b1;
            r_applied   <= 1'b1;
            r_dwell_cnt <= '0;
            r_state     <= ST_DWELL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        // Unreachable in this build; recover to idle.
        ST_RAMP: r_state <= ST_IDLE;
`endif
        ST_DWELL: begin
          if (w_edge) begin
            if (r_dwell_cnt == DWELL_LAST) begin
              r_state <= ST_IDLE;
            end else begin
              r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign max_out   = r_max;
  assign applied   = r_applied;
  assign clamped   = r_clamped;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Closed-loop bench for clk_rate_ctrl driving a behavioural divider model. Stimulus pushes
// the expected final state of each rate change into a queue; a monitor pops an entry on
// every applied pulse and compares. Directed timing checks run inline with the stimulus.
module tb_clk_rate_ctrl;

  typedef struct {
    logic [31:0] max;
    logic        clamped;
    logic        timeout;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_max;
  logic        req_ready;
  logic        div_clk;
  logic [31:0] max_out;
  logic        busy;
  logic        applied;
  logic        clamped;
  logic        timeout;

  logic [31:0] div_cnt;
  logic        new_clk;
  logic        force_low;

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  clk_rate_ctrl #(
    .DEFAULT_MAX (32'd9),
    .MIN_MAX     (32'd1),
    .DWELL_EDGES (4),
    .TIMEOUT_CYC (32'd50)
`ifdef CLK_RATE_RAMP_EN
    ,
    .RAMP_STEP   (32'd2)
`endif
  ) u_dut (
    .clk_in    (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_max   (req_max),
    .req_ready (req_ready),
    .div_clk   (div_clk),
    .max_out   (max_out),
    .busy      (busy),
    .applied   (applied),
    .clamped   (clamped),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: toggles new_clk every max+1 cycles.
  always @(posedge clk) begin
    if (rst) begin
      div_cnt <= 32'd0;
      new_clk <= 1'b0;
    end else if (div_cnt >= max_out) begin
      div_cnt <= 32'd0;
      new_clk <= ~new_clk;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  assign div_clk = new_clk & ~force_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && applied) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_applied: got applied with max_out=%0d, expected none",
                 max_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_max_out", max_out, e.max);
        check("sb_clamped", {31'd0, clamped}, {31'd0, e.clamped});
        check("sb_timeout", {31'd0, timeout}, {31'd0, e.timeout});
      end
    end
  end

  task automatic push_exp(input logic [31:0] m, input logic c, input logic t);
    exp_t e;
    e.max = m;
    e.clamped = c;
    e.timeout = t;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] v);
    for (int i = 0; i < 2000 && !req_ready; i++) @(negedge clk);
    check("send_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_max   = v;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && !req_ready; i++) @(negedge clk);
    check("wait_idle", {31'd0, req_ready}, 32'd1);
  endtask

  // Stops at the negedge of the first cycle where div_clk is newly high.
  task automatic wait_rise();
    logic prev;
    logic seen;
    prev = div_clk;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (div_clk && !prev) seen = 1'b1;
      prev = div_clk;
    end
    check("wait_rise", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_max_out"}, max_out, 32'd9);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_applied"}, {31'd0, applied}, 32'd0);
    check({tag, "_clamped"}, {31'd0, clamped}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_max   = 32'd0;
    force_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

`ifdef CLK_RATE_RAMP_EN
    // Ramp 9 -> 2 in steps of 2.
    push_exp(32'd2, 1'b0, 1'b0);
    send(32'd2);
    wait_rise();
    @(negedge clk);
    check("ramp_step1", max_out, 32'd7);
    check("ramp_step1_applied", {31'd0, applied}, 32'd0);
    wait_rise();
    @(negedge clk);
    check("ramp_step2", max_out, 32'd5);
    check("ramp_step2_applied", {31'd0, applied}, 32'd0);
    wait_rise();
    @(negedge clk);
    check("ramp_step3", max_out, 32'd3);
    check("ramp_step3_applied", {31'd0, applied}, 32'd0);
    wait_rise();
    @(negedge clk);
    check("ramp_step4", max_out, 32'd2);
    check("ramp_step4_applied", {31'd0, applied}, 32'd1);
    wait_idle();
`else
    // Basic change 9 -> 3 on the next divided edge, then a 4-edge dwell.
    push_exp(32'd3, 1'b0, 1'b0);
    send(32'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready", {31'd0, req_ready}, 32'd0);
    check("t1_hold_max", max_out, 32'd9);
    wait_rise();
    check("t1_edge_cycle_max", max_out, 32'd9);
    @(negedge clk);
    check("t1_new_max", max_out, 32'd3);
    check("t1_applied", {31'd0, applied}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      wait_rise();
      check("t1_dwell_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("t1_dwell_done_busy", {31'd0, busy}, 32'd0);
    check("t1_dwell_done_ready", {31'd0, req_ready}, 32'd1);
`endif

    // Clamp: request 0 -> target 1, clamped set; next accept clears it.
    push_exp(32'd1, 1'b1, 1'b0);
    send(32'd0);
    check("t2_clamped_set", {31'd0, clamped}, 32'd1);
    wait_idle();
    check("t2_max_clamped", max_out, 32'd1);
    push_exp(32'd5, 1'b0, 1'b0);
    send(32'd5);
    check("t2_clamped_clear", {31'd0, clamped}, 32'd0);
    wait_idle();

    // Same-value request: applied one cycle after accept, never busy.
    push_exp(32'd9, 1'b0, 1'b0);
    send(32'd9);
    wait_idle();
    push_exp(32'd9, 1'b0, 1'b0);
    send(32'd9);
    check("t3_applied", {31'd0, applied}, 32'd1);
    check("t3_busy0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t3_busy1", {31'd0, busy}, 32'd0);
    check("t3_applied_once", {31'd0, applied}, 32'd0);

    // Timeout: divided clock held low, change forced 50 cycles after accept.
    force_low = 1'b1;
    push_exp(32'd4, 1'b0, 1'b1);
    send(32'd4);
    repeat (49) @(negedge clk);
    check("t4_before_timeout", max_out, 32'd9);
    check("t4_no_timeout_yet", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    check("t4_forced_max", max_out, 32'd4);
    check("t4_timeout_flag", {31'd0, timeout}, 32'd1);
    @(posedge clk);
    #1;
    force_low = 1'b0;
    wait_idle();
    check("t4_timeout_sticky", {31'd0, timeout}, 32'd1);

    // Reset mid-wait abandons the change and clears every flag.
    force_low = 1'b1;
    send(32'd0);
    check("t5_busy", {31'd0, busy}, 32'd1);
    check("t5_clamped", {31'd0, clamped}, 32'd1);
    check("t5_timeout_cleared", {31'd0, timeout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("t5_rst");
    force_low = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
